// File: rtl/clk_div_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for a fractional clock divider.
// Resets the divider, then dwells and steps the {div,div_frac} word by a signed increment.
module clk_div_sweep_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int MIN_DIV    = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [9:0]  cfg_start_div_i,
    input  logic [21:0] cfg_start_frac_i,
    input  logic [31:0] cfg_step_i,
    input  logic [15:0] cfg_num_steps_i,
    input  logic [15:0] cfg_dwell_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        rader_pulse_i,
    output logic [9:0]  div_o,
    output logic [21:0] div_frac_o,
    output logic        div_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        step_strobe_o,
    output logic [15:0] step_idx_o
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_e;

    localparam int ARM_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [9:0]         start_div_q, start_div_d;
    logic [21:0]        start_frac_q, start_frac_d;
    logic [31:0]        step_q, step_d;
    logic [15:0]        num_steps_q, num_steps_d;
    logic [15:0]        dwell_q, dwell_d;
    logic [31:0]        word_q, word_d;
    logic               div_rst_q, div_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               strobe_q, strobe_d;
    logic [15:0]        step_idx_q, step_idx_d;
    logic [15:0]        dwell_cnt_q, dwell_cnt_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;

    logic               cfg_load;
    logic [15:0]        eff_dwell;
    logic               dwell_hit;
    logic [32:0]        step_sum;
    logic               step_bad;

    // Sign-extending the step into 33 bits makes bit 32 flag both carry and borrow.
    assign step_sum  = {1'b0, word_q} + {step_q[31], step_q};
    assign step_bad  = step_sum[32] || (step_sum[31:22] < 10'(MIN_DIV));
    assign eff_dwell = (dwell_q == 16'd0) ? 16'd1 : dwell_q;
    assign dwell_hit = (dwell_cnt_q == eff_dwell - 16'd1);
    assign cfg_load  = cfg_valid_i && (state_q == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_div_q  <= 10'(MIN_DIV);
            start_frac_q <= '0;
            step_q       <= '0;
            num_steps_q  <= '0;
            dwell_q      <= 16'd1;
            word_q       <= {10'(MIN_DIV), 22'd0};
            div_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            strobe_q     <= 1'b0;
            step_idx_q   <= '0;
            dwell_cnt_q  <= '0;
            arm_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_div_q  <= start_div_d;
            start_frac_q <= start_frac_d;
            step_q       <= step_d;
            num_steps_q  <= num_steps_d;
            dwell_q      <= dwell_d;
            word_q       <= word_d;
            div_rst_q    <= div_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
            strobe_q     <= strobe_d;
            step_idx_q   <= step_idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
            arm_cnt_q    <= arm_cnt_d;
        end
    end

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        start_div_d  = start_div_q;
        start_frac_d = start_frac_q;
        step_d       = step_q;
        num_steps_d  = num_steps_q;
        dwell_d      = dwell_q;
        word_d       = word_q;
        div_rst_d    = div_rst_q;
        done_d       = 1'b0;
        err_d        = err_q;
        strobe_d     = 1'b0;
        step_idx_d   = step_idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        arm_cnt_d    = arm_cnt_q;

        if (cfg_load) begin
            start_div_d  = cfg_start_div_i;
            start_frac_d = cfg_start_frac_i;
            step_d       = cfg_step_i;
            num_steps_d  = cfg_num_steps_i;
            dwell_d      = cfg_dwell_i;
        end

        if (abort_i) begin
            state_d   = IDLE;
            div_rst_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d     = ARM;
                        word_d      = cfg_load ? {cfg_start_div_i, cfg_start_frac_i}
                                               : {start_div_q, start_frac_q};
                        div_rst_d   = 1'b1;
                        step_idx_d  = '0;
                        strobe_d    = 1'b1;
                        err_d       = 1'b0;
                        dwell_cnt_d = '0;
                        arm_cnt_d   = '0;
                    end
                end
                ARM: begin
                    if (arm_cnt_q == ARM_W'(RST_CYCLES - 1)) begin
                        state_d   = RUN;
                        div_rst_d = 1'b0;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (rader_pulse_i) begin
                        if (!dwell_hit) begin
                            dwell_cnt_d = dwell_cnt_q + 16'd1;
                        end else if (step_idx_q == num_steps_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (step_bad) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                        end else begin
                            word_d      = step_sum[31:0];
                            step_idx_d  = step_idx_q + 16'd1;
                            strobe_d    = 1'b1;
                            dwell_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ready_o   = (state_q == IDLE);
        busy_o        = (state_q != IDLE);
        div_o         = word_q[31:22];
        div_frac_o    = word_q[21:0];
        div_rst_o     = div_rst_q;
        done_o        = done_q;
        err_o         = err_q;
        step_strobe_o = strobe_q;
        step_idx_o    = step_idx_q;
    end

endmodule

// File: tb/tb_clk_div_sweep_ctrl.sv
// Directed bench for clk_div_sweep_ctrl: a table of full sweeps plus hand-written
// sequences for divider-reset timing, abort and config-acceptance corner cases.
module tb_clk_div_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [9:0]  cfg_start_div;
    logic [21:0] cfg_start_frac;
    logic [31:0] cfg_step;
    logic [15:0] cfg_num_steps;
    logic [15:0] cfg_dwell;
    logic        start;
    logic        abort;
    logic        rader_pulse;
    logic [9:0]  div;
    logic [21:0] div_frac;
    logic        div_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic        step_strobe;
    logic [15:0] step_idx;

    int n_vec  = 0;
    int n_fail = 0;

    clk_div_sweep_ctrl #(.RST_CYCLES(4), .MIN_DIV(20)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid_i      (cfg_valid),
        .cfg_ready_o      (cfg_ready),
        .cfg_start_div_i  (cfg_start_div),
        .cfg_start_frac_i (cfg_start_frac),
        .cfg_step_i       (cfg_step),
        .cfg_num_steps_i  (cfg_num_steps),
        .cfg_dwell_i      (cfg_dwell),
        .start_i          (start),
        .abort_i          (abort),
        .rader_pulse_i    (rader_pulse),
        .div_o            (div),
        .div_frac_o       (div_frac),
        .div_rst_o        (div_rst),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err),
        .step_strobe_o    (step_strobe),
        .step_idx_o       (step_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  sdiv;
        logic [21:0] sfrac;
        logic [31:0] step;
        logic [15:0] nsteps;
        logic [15:0] dwell;
        logic [9:0]  exp_div;
        logic [21:0] exp_frac;
        logic        exp_err;
        int          exp_strobes;
        int          exp_pulses;
        logic [15:0] exp_idx;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [9:0] sdiv, input logic [21:0] sfrac, input logic [31:0] step,
                           input logic [15:0] nsteps, input logic [15:0] dwell);
        cfg_start_div  = sdiv;
        cfg_start_frac = sfrac;
        cfg_step       = step;
        cfg_num_steps  = nsteps;
        cfg_dwell      = dwell;
    endtask

    // Loads config, starts, and returns at the first cycle after start (N+1).
    task automatic load_and_start();
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic pulse_once();
        rader_pulse = 1'b1;
        tick();
        rader_pulse = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int  strobes;
        int  pulses;
        logic got_done;
        string tag;
        tag      = $sformatf("v%0d", k);
        strobes  = 0;
        pulses   = 0;
        got_done = 1'b0;
        set_cfg(v.sdiv, v.sfrac, v.step, v.nsteps, v.dwell);
        load_and_start();
        check({tag, "_arm_div"},    32'(div),      32'(v.sdiv));
        check({tag, "_arm_frac"},   32'(div_frac), 32'(v.sfrac));
        check({tag, "_arm_rst"},    32'(div_rst),  32'd1);
        check({tag, "_arm_busy"},   32'(busy),     32'd1);
        check({tag, "_arm_err"},    32'(err),      32'd0);
        if (step_strobe) strobes++;
        repeat (4) tick();
        for (int i = 0; i < 200 && !got_done; i++) begin
            pulse_once();
            pulses++;
            if (step_strobe) strobes++;
            if (done) got_done = 1'b1;
            else tick();
        end
        check({tag, "_done_seen"}, 32'(got_done),  32'd1);
        check({tag, "_pulses"},    32'(pulses),    32'(v.exp_pulses));
        check({tag, "_strobes"},   32'(strobes),   32'(v.exp_strobes));
        check({tag, "_div"},       32'(div),       32'(v.exp_div));
        check({tag, "_frac"},      32'(div_frac),  32'(v.exp_frac));
        check({tag, "_err"},       32'(err),       32'(v.exp_err));
        check({tag, "_idx"},       32'(step_idx),  32'(v.exp_idx));
        check({tag, "_busy_end"},  32'(busy),      32'd0);
        tick();
        check({tag, "_done_1cyc"}, 32'(done),      32'd0);
    endtask

    initial begin
        int rst_cycles;

        //          sdiv  sfrac      step          N     dwell div   frac      err strb pul idx
        vecs[0] = '{10'd100, 22'h0,      32'h0040_0000, 16'd2, 16'd3, 10'd102, 22'h0,      1'b0, 3, 9, 16'd2};
        vecs[1] = '{10'd21,  22'h0,      32'hFF80_0000, 16'd1, 16'd2, 10'd21,  22'h0,      1'b1, 1, 2, 16'd0};
        vecs[2] = '{10'd50,  22'h3FFFFF, 32'h0000_0001, 16'd1, 16'd1, 10'd51,  22'h0,      1'b0, 2, 2, 16'd1};
        vecs[3] = '{10'd30,  22'h0,      32'h0040_0000, 16'd0, 16'd0, 10'd30,  22'h0,      1'b0, 1, 1, 16'd0};
        vecs[4] = '{10'd1023,22'h3FFFFF, 32'h0000_0001, 16'd3, 16'd1, 10'd1023,22'h3FFFFF, 1'b1, 1, 1, 16'd0};
        vecs[5] = '{10'd22,  22'h0,      32'hFF80_0000, 16'd1, 16'd1, 10'd20,  22'h0,      1'b0, 2, 2, 16'd1};
        vecs[6] = '{10'd20,  22'h0,      32'hFFFF_FFFF, 16'd1, 16'd1, 10'd20,  22'h0,      1'b1, 1, 1, 16'd0};
        vecs[7] = '{10'd20,  22'h0,      32'h8000_0000, 16'd1, 16'd1, 10'd20,  22'h0,      1'b1, 1, 1, 16'd0};

        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; rader_pulse = 1'b0;
        set_cfg(10'd0, 22'd0, 32'd0, 16'd0, 16'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_div",      32'(div),         32'd20);
        check("rst_frac",     32'(div_frac),    32'd0);
        check("rst_div_rst",  32'(div_rst),     32'd1);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_done",     32'(done),        32'd0);
        check("rst_err",      32'(err),         32'd0);
        check("rst_strobe",   32'(step_strobe), 32'd0);
        check("rst_idx",      32'(step_idx),    32'd0);
        check("rst_ready",    32'(cfg_ready),   32'd1);

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Divider reset width, and pulses during ARM must not count toward dwell.
        set_cfg(10'd60, 22'h0, 32'h0040_0000, 16'd1, 16'd2);
        load_and_start();
        rader_pulse = 1'b1;
        rst_cycles  = 0;
        for (int i = 0; i < 20 && div_rst; i++) begin
            rst_cycles++;
            tick();
        end
        rader_pulse = 1'b0;
        check("arm_rst_cycles", 32'(rst_cycles), 32'd4);
        check("arm_busy_run",   32'(busy),       32'd1);
        pulse_once();
        check("arm_p1_strobe",  32'(step_strobe), 32'd0);
        check("arm_p1_div",     32'(div),         32'd60);
        pulse_once();
        check("arm_p2_strobe",  32'(step_strobe), 32'd1);
        check("arm_p2_div",     32'(div),         32'd61);
        pulse_once();
        pulse_once();
        check("arm_done",       32'(done),        32'd1);
        tick();

        // Abort mid-RUN at step 1.
        set_cfg(10'd100, 22'h0, 32'h0040_0000, 16'd5, 16'd2);
        load_and_start();
        repeat (4) tick();
        pulse_once();
        pulse_once();
        check("ab_step1_idx", 32'(step_idx), 32'd1);
        pulse_once();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy",    32'(busy),      32'd0);
        check("ab_done",    32'(done),      32'd0);
        check("ab_div",     32'(div),       32'd101);
        check("ab_idx",     32'(step_idx),  32'd1);
        check("ab_ready",   32'(cfg_ready), 32'd1);
        check("ab_div_rst", 32'(div_rst),   32'd0);
        pulse_once();
        check("ab_hold_div", 32'(div),  32'd101);
        check("ab_no_done",  32'(done), 32'd0);

        // Config ignored while running; config+start in the same cycle uses new values.
        set_cfg(10'd30, 22'h0, 32'h0040_0000, 16'd1, 16'd0);
        load_and_start();
        repeat (4) tick();
        check("cfg_ready_run", 32'(cfg_ready), 32'd0);
        cfg_start_div = 10'd200;
        cfg_valid     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        pulse_once();
        check("cfg_run_step", 32'(div), 32'd31);
        pulse_once();
        check("cfg_run_done", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("cfg_kept_div", 32'(div), 32'd30);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cfg_start_div = 10'd40;
        cfg_valid     = 1'b1;
        start         = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("cfg_same_div",    32'(div),         32'd40);
        check("cfg_same_strobe", 32'(step_strobe), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
